fp_mul_iter: RTL and testbench
==============================

Name: fp_mul_iter

Overview:
- Parametrised IEEE-754-style floating-point multiplier with a configurable exponent/fraction width.
- Uses an iterative radix-4 Booth significand datapath and a valid/ready handshake on input and output.
- Successor to the single-cycle single-precision multiplier; it adds width generality, multi-cycle operation with backpressure, and IEEE-correct directed rounding.
- Sits in the FPU ALU beside the add/sub unit and is driven by the FPU issue stage.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- FRC_W, 23, stored fraction width (≥2); total operand width W = 1+EXP_W+FRC_W.
- N_ITER, (FRC_W+3)/2 (integer division), Booth iterations; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept (high only in IDLE)
- fp_X  in  W  operand X
- fp_Y  in  W  operand Y
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fp_Z  out  W  product
- ovrf  out  1  overflow
- udrf  out  1  underflow (result flushed to zero)
- nx  out  1  inexact

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, fp_Z=0, ovrf=0, udrf=0, nx=0.
- rst mid-operation aborts the operation and discards it; no result is produced.
- Accept: a transfer occurs when in_valid && in_ready at a clock edge. fp_X, fp_Y and r_mode are latched then; later input changes are ignored.
- Operand classes:
  - sub = exp==0; subnormals are treated as signed zero (DAZ).
  - inf = exp all-ones with frac==0.
  - nan = exp all-ones with frac!=0.
- Sign: sign_Z = X.sign ^ Y.sign for every non-NaN result.
- FSM: IDLE → (MULT | DONE) → … → DONE → IDLE.
- IDLE: on accept, classify the operands.
  - Any special operand (zero/sub/inf/nan) → DONE next cycle, latency 1.
  - Otherwise → MULT; clear the accumulator and set the iteration counter to 0.
- MULT: one radix-4 Booth step per cycle.
  - Multiplicand is the (FRC_W+1)-bit significand with the hidden 1. The multiplier is zero-extended to 2·N_ITER+1 bits.
  - Each step adds a partial product of {0, ±M, ±2M} and shifts right by 2.
  - After N_ITER cycles, the exact 2·(FRC_W+1)-bit product is held in frc_full → NORM_RND.
- NORM_RND (1 cycle):
  - If frc_full MSB is set, exponent +1; otherwise shift left 1.
  - Form the FRC_W+4-bit vector {1, frac, G, R, S}, where S is the OR of all lower bits.
  - Round per r_mode:
    - RNE: +1 if G && (R|S|lsb).
    - RTZ: never round.
    - RDN: +1 if sign && (G|R|S).
    - RUP: +1 if !sign && (G|R|S).
    - RMM: +1 if G.
  - A rounding carry out of the significand increments the exponent; the fraction becomes 0.
  - nx = G|R|S.
  - → DONE.
- Exponent arithmetic: EXP_W+2-bit signed, e = eX + eY − bias + norm + carry.
  - e ≥ all-ones → overflow, ovrf=1, nx=1. Result is inf for RNE/RMM, for RUP with +, and for RDN with −; otherwise it is max finite (exp=all-ones−1, frac=all-ones).
  - e ≤ 0 → signed zero, udrf=1, nx=1.
- Special results:
  - NaN, or inf×zero → canonical quiet NaN: sign 0, exp all-ones, frac MSB 1, rest 0. No flags.
  - inf×finite-nonzero → signed inf.
  - zero/sub × finite → signed zero.
  - Flags are 0 for all special results.
- DONE: out_valid=1; fp_Z and the flags are stable until out_valid && out_ready, then → IDLE in the same edge.
  - There is no accept in the cycle the result is taken (in_ready=0 in DONE).
  - Latency is 1 cycle for specials and N_ITER+2 cycles otherwise (15 at defaults), measured from the accept edge to the first out_valid.

Decomposition:
- Package fp_mul_pkg:
  - r_mode_e enum.
  - state_e (IDLE, MULT, NORM_RND, DONE).
  - Functions: bias(EXP_W), canonical_nan(EXP_W,FRC_W), max_finite.
- Sub-module fp_booth_r4_step: combinational Booth-digit select and partial-product add for one iteration, instantiated once. The FSM, normalisation and rounding live in the top module.

Test Plan:
- fp_X=0x40400000, fp_Y=0x40400000, RTZ → fp_Z=0x41100000, flags 0, out_valid 15 cycles after accept.
- fp_X=fp_Y=0x3F800001:
  - RNE → 0x3F800002, nx=1.
  - RUP → 0x3F800003.
  - RDN with fp_X=0xBF800001 → 0xBF800003.
- fp_X=0x7F000000, fp_Y=0x40000000:
  - RNE → 0x7F800000, ovrf=1.
  - RTZ → 0x7F7FFFFF, ovrf=1.
- Underflow and DAZ:
  - fp_X=0x00800000, fp_Y=0x3F000000 → 0x00000000, udrf=1.
  - fp_X=0x002DF854 (sub), fp_Y=0xC0490FDB → 0x80000000, flags 0, latency 1.
- Specials:
  - fp_X=0x7F800000, fp_Y=0x00000000 → 0x7FC00000.
  - fp_X=0xFF800000, fp_Y=0x40000000 → 0xFF800000.
- Handshake: hold out_ready=0 for 5 cycles in DONE → fp_Z stable, in_ready=0. Assert rst in cycle 4 of MULT → out_valid stays 0, in_ready=1 the next cycle, and a fresh 1.0×1.0 returns 0x3F800000.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constant helpers for the iterative FP multiplier.
// Rounding modes, FSM states and IEEE encoding builders.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } r_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM_RND,
    DONE
  } state_e;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [63:0] exp_ones(input int ew);
    return (64'd1 << ew) - 64'd1;
  endfunction

  function automatic logic [63:0] canonical_nan(
    input int ew,
    input int fw
  );
    return (exp_ones(ew) << fw) | (64'd1 << (fw - 1));
  endfunction

  // Magnitude only (no sign bit).
  function automatic logic [63:0] max_finite(
    input int ew,
    input int fw
  );
    return ((exp_ones(ew) - 64'd1) << fw)
         | ((64'd1 << fw) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_mul_iter_booth.sv
// One radix-4 Booth iteration: digit select, partial-product add
// and a 2-bit arithmetic right shift of the {hi, lo, q} accumulator.
module fp_booth_r4_step
  import fp_mul_pkg::*;
#(
  parameter int SW = 24,
  parameter int ML = 26
) (
  input  logic [SW-1:0]    mcand,
  input  logic [SW+ML+3:0] acc_in,
  output logic [SW+ML+3:0] acc_out
);

  localparam int HW = SW + 3;

  logic [2:0]    trip;
  logic [HW-1:0] m1;
  logic [HW-1:0] m2;
  logic [HW-1:0] pp;
  logic [HW-1:0] hi_sum;

  assign trip = acc_in[2:0];
  assign m1   = {3'b000, mcand};
  assign m2   = {2'b00, mcand, 1'b0};

  always_comb begin
    pp = '0;
    unique case (1'b1)
      (trip == 3'b001),
      (trip == 3'b010): pp = m1;
      (trip == 3'b011): pp = m2;
      (trip == 3'b100): pp = -m2;
      (trip == 3'b101),
      (trip == 3'b110): pp = -m1;
      default:          pp = '0;
    endcase
  end

  assign hi_sum  = acc_in[SW+ML+3:ML+1] + pp;
  assign acc_out = {{2{hi_sum[HW-1]}}, hi_sum, acc_in[ML:2]};

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative radix-4 Booth FP multiplier with valid/ready handshake,
// DAZ inputs, flush-to-zero underflow and IEEE directed rounding.
module fp_mul_iter
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+FRC_W:0]   fp_X,
  input  logic [EXP_W+FRC_W:0]   fp_Y,
  input  logic [2:0]             r_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRC_W:0]   fp_Z,
  output logic                   ovrf,
  output logic                   udrf,
  output logic                   nx
);

  localparam int W      = 1 + EXP_W + FRC_W;
  localparam int WM     = W - 1;
  localparam int SW     = FRC_W + 1;
  localparam int N_ITER = (FRC_W + 3) / 2;
  localparam int ML     = 2 * N_ITER;
  localparam int AW     = SW + ML + 4;
  localparam int EW     = EXP_W + 2;
  localparam int CW     = $clog2(N_ITER);
  localparam int FW1    = FRC_W + 1;

  localparam logic [W-1:0]  QNAN =
    W'(canonical_nan(EXP_W, FRC_W));
  localparam logic [W-2:0]  MAXF =
    WM'(max_finite(EXP_W, FRC_W));
  localparam logic [W-2:0]  INF  =
    {{EXP_W{1'b1}}, {FRC_W{1'b0}}};
  localparam logic [EW-1:0] BIAS_E = EW'(bias(EXP_W));
  localparam logic [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] LAST   = CW'(N_ITER - 1);

  state_e          state;
  state_e          nxt;
  r_mode_e         rm;
  logic            sgn;
  logic [EW-1:0]   e_base;
  logic [SW-1:0]   mcand;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_nx;
  logic [CW-1:0]   cnt;
  logic [2*SW-1:0] frc_full;

  logic [EXP_W-1:0] xe, ye;
  logic [FRC_W-1:0] xf, yf;
  logic x_zero, x_inf, x_nan;
  logic y_zero, y_inf, y_nan;
  logic special, s_in;
  logic [W-1:0] spec_z;

  assign xe = fp_X[W-2:FRC_W];
  assign ye = fp_Y[W-2:FRC_W];
  assign xf = fp_X[FRC_W-1:0];
  assign yf = fp_Y[FRC_W-1:0];
  assign s_in = fp_X[W-1] ^ fp_Y[W-1];

  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (xe == '1) && (xf == '0);
  assign y_inf  = (ye == '1) && (yf == '0);
  assign x_nan  = (xe == '1) && (xf != '0);
  assign y_nan  = (ye == '1) && (yf != '0);

  assign special = x_zero | x_inf | x_nan
                 | y_zero | y_inf | y_nan;

  always_comb begin
    spec_z = {s_in, {WM{1'b0}}};
    if (x_nan || y_nan || (x_inf && y_zero)
        || (x_zero && y_inf))
      spec_z = QNAN;
    else if (x_inf || y_inf)
      spec_z = {s_in, INF};
  end

  fp_booth_r4_step #(
    .SW (SW),
    .ML (ML)
  ) u_step (
    .mcand   (mcand),
    .acc_in  (acc),
    .acc_out (acc_nx)
  );

  assign frc_full = acc[2*SW:1];

  // Normalise and round the exact product held in frc_full.
  logic [2*SW-2:0] fx;
  logic            g, r, s_b, inexact, inc, to_inf;
  logic [FRC_W:0]  fsum;
  logic [EW-1:0]   e_fin;
  logic [W-1:0]    z_rnd;
  logic            ovf_rnd, udf_rnd, nx_rnd;

  always_comb begin
    fx = frc_full[2*SW-1] ? frc_full[2*SW-2:0]
                          : {frc_full[2*SW-3:0], 1'b0};
    g       = fx[SW-1];
    r       = fx[SW-2];
    s_b     = |fx[SW-3:0];
    inexact = g | r | s_b;
    inc     = 1'b0;
    unique case (1'b1)
      (rm == RM_RTZ): inc = 1'b0;
      (rm == RM_RDN): inc = sgn & inexact;
      (rm == RM_RUP): inc = ~sgn & inexact;
      (rm == RM_RMM): inc = g;
      default:        inc = g & (r | s_b | fx[SW]);
    endcase
    fsum  = {1'b0, fx[2*SW-2:SW]} + FW1'(inc);
    e_fin = e_base + EW'(frc_full[2*SW-1])
          + EW'(fsum[FRC_W]);
    to_inf = !((rm == RM_RTZ)
            || (rm == RM_RUP && sgn)
            || (rm == RM_RDN && !sgn));
    z_rnd   = {sgn, e_fin[EXP_W-1:0], fsum[FRC_W-1:0]};
    ovf_rnd = 1'b0;
    udf_rnd = 1'b0;
    nx_rnd  = inexact;
    if (!e_fin[EW-1] && (e_fin >= EMAX)) begin
      ovf_rnd = 1'b1;
      nx_rnd  = 1'b1;
      z_rnd   = {sgn, to_inf ? INF : MAXF};
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      udf_rnd = 1'b1;
      nx_rnd  = 1'b1;
      z_rnd   = {sgn, {WM{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (in_valid) nxt = special ? DONE : MULT;
      MULT:     if (cnt == LAST) nxt = NORM_RND;
      NORM_RND: nxt = DONE;
      DONE:     if (out_ready) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rm     <= RM_RNE;
      sgn    <= 1'b0;
      e_base <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      fp_Z   <= '0;
      ovrf   <= 1'b0;
      udrf   <= 1'b0;
      nx     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          rm     <= r_mode_e'(r_mode);
          sgn    <= s_in;
          e_base <= EW'(xe) + EW'(ye) - BIAS_E;
          mcand  <= {1'b1, xf};
          acc    <= {{(SW+3){1'b0}},
                     ML'({1'b1, yf}), 1'b0};
          cnt    <= '0;
          fp_Z   <= spec_z;
          ovrf   <= 1'b0;
          udrf   <= 1'b0;
          nx     <= 1'b0;
        end
        MULT: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
        end
        NORM_RND: begin
          fp_Z <= z_rnd;
          ovrf <= ovf_rnd;
          udrf <= udf_rnd;
          nx   <= nx_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed and random checks of fp_mul_iter against an integer
// reference model of single-precision multiply with DAZ/FTZ.
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  r_mode = 3'd0;
  logic [31:0] fp_X = '0;
  logic [31:0] fp_Y = '0;
  logic        in_ready, out_valid;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, nx;

  int errors = 0;
  int checks = 0;

  fp_mul_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .nx        (nx)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Exact integer product, then round by comparing the
  // discarded remainder with half an ulp.
  function automatic void model(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [2:0]  rm,
    output logic [31:0] z,
    output logic [2:0]  fl,
    output int          lat
  );
    logic   s, xz, yz, xi, yi, xn, yn, inc, to_inf;
    int     ex, ey, e;
    longint p, keep, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    fl  = 3'b000;
    lat = 1;
    if (xn || yn || (xi && yz) || (xz && yi))
      z = 32'h7FC00000;
    else if (xi || yi)
      z = {s, 8'hFF, 23'h0};
    else if (xz || yz)
      z = {s, 31'h0};
    else begin
      lat = 15;
      p = longint'({1'b1, x[22:0]})
        * longint'({1'b1, y[22:0]});
      e = ex + ey - 127;
      if (p >= (64'sd1 << 47)) begin
        e++;
        keep = p >> 24;
        rem  = p % (64'sd1 << 24);
        half = 64'sd1 << 23;
      end else begin
        keep = p >> 23;
        rem  = p % (64'sd1 << 23);
        half = 64'sd1 << 22;
      end
      case (rm)
        3'd1:    inc = 1'b0;
        3'd2:    inc = s && (rem != 0);
        3'd3:    inc = !s && (rem != 0);
        3'd4:    inc = (rem >= half);
        default: inc = (rem > half)
                    || ((rem == half) && keep[0]);
      endcase
      keep = keep + longint'(inc);
      if (keep == (64'sd1 << 24)) begin
        keep = 64'sd1 << 23;
        e++;
      end
      if (e >= 255) begin
        fl = 3'b101;
        to_inf = !((rm == 3'd1) || (rm == 3'd3 && s)
                || (rm == 3'd2 && !s));
        z = to_inf ? {s, 8'hFF, 23'h0}
                   : {s, 8'hFE, 23'h7FFFFF};
      end else if (e <= 0) begin
        fl = 3'b011;
        z  = {s, 31'h0};
      end else begin
        fl = {2'b00, rem != 0};
        z  = {s, 8'(e), keep[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    f = 23'($urandom);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'd255;
    else if (k < 5)  e = 8'($urandom_range(1, 30));
    else if (k < 8)  e = 8'($urandom_range(220, 254));
    else             e = 8'($urandom_range(90, 160));
    if (k == 1 && $urandom_range(0, 1) == 1) f = '0;
    if (k == 9) f = '1;
    return {1'($urandom), e, f};
  endfunction

  task automatic run_op(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [2:0]  rm,
    input logic [31:0] ez,
    input logic [2:0]  ef,
    input int          el,
    input string       tag
  );
    int lat;
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_X = $urandom;
    fp_Y = $urandom;
    r_mode = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "/valid"}, 64'(out_valid), 64'd1);
    chk({tag, "/lat"}, 64'(lat), 64'(el));
    chk({tag, "/z"}, 64'(fp_Z), 64'(ez));
    chk({tag, "/flags"}, 64'({ovrf, udrf, nx}), 64'(ef));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] x, y, ez;
    logic [2:0]  rm, ef;
    int          el, n;
    logic        seen;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/in_ready", 64'(in_ready), 64'd1);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/z", 64'(fp_Z), 64'd0);
    chk("rst/flags", 64'({ovrf, udrf, nx}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(32'h40400000, 32'h40400000, 3'd1,
           32'h41100000, 3'b000, 15, "3x3_rtz");
    run_op(32'h3F800001, 32'h3F800001, 3'd0,
           32'h3F800002, 3'b001, 15, "ulp_rne");
    run_op(32'h3F800001, 32'h3F800001, 3'd3,
           32'h3F800003, 3'b001, 15, "ulp_rup");
    run_op(32'hBF800001, 32'h3F800001, 3'd2,
           32'hBF800003, 3'b001, 15, "ulp_rdn");
    run_op(32'h3F800001, 32'h3F800001, 3'd7,
           32'h3F800002, 3'b001, 15, "ulp_rm7");
    run_op(32'h7F000000, 32'h40000000, 3'd0,
           32'h7F800000, 3'b101, 15, "ovf_rne");
    run_op(32'h7F000000, 32'h40000000, 3'd1,
           32'h7F7FFFFF, 3'b101, 15, "ovf_rtz");
    run_op(32'h00800000, 32'h3F000000, 3'd0,
           32'h00000000, 3'b011, 15, "udf");
    run_op(32'h002DF854, 32'hC0490FDB, 3'd0,
           32'h80000000, 3'b000, 1, "daz");
    run_op(32'h7F800000, 32'h00000000, 3'd0,
           32'h7FC00000, 3'b000, 1, "inf_x_0");
    run_op(32'hFF800000, 32'h40000000, 3'd0,
           32'hFF800000, 3'b000, 1, "ninf_x_2");

    // Backpressure: result must hold and no accept in DONE.
    fp_X = 32'h3F800000;
    fp_Y = 32'h40000000;
    r_mode = 3'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp/valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      fp_X = $urandom;
      fp_Y = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp/hold_valid", 64'(out_valid), 64'd1);
      chk("bp/hold_z", 64'(fp_Z), 64'h40000000);
      chk("bp/in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp/drain_valid", 64'(out_valid), 64'd0);
    chk("bp/drain_ready", 64'(in_ready), 64'd1);

    // Abort an operation in its fourth MULT cycle.
    fp_X = 32'h40400000;
    fp_Y = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort/out_valid", 64'(out_valid), 64'd0);
    chk("abort/in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("abort/no_result", 64'(seen), 64'd0);
    run_op(32'h3F800000, 32'h3F800000, 3'd0,
           32'h3F800000, 3'b000, 15, "abort/fresh");

    for (int i = 0; i < 60; i++) begin
      x  = rand_op();
      y  = rand_op();
      rm = 3'($urandom_range(0, 7));
      model(x, y, rm, ez, ef, el);
      run_op(x, y, rm, ez, ef, el, "rand");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
